audio_i2s_ctrl: RTL and testbench
=================================

Name: audio_i2s_ctrl

Overview:
Sequencer and buffer for the board audio DAC serial link. It accepts stereo 16-bit sample pairs from the APU mixer over a valid/ready handshake and buffers them in a small FIFO. It generates the DAC bit clock and LR clock from the system clock, and shifts each pair out MSB-first, one pair per LR frame. It handles start/stop at frame boundaries and underrun (hold or mute), so the DAC datapath never sees a partial frame.

Parameters:
BCLK_HALF, 6, clk cycles per BCLK half-period (18.432 MHz / 6 / 2 = 1.536 MHz = 48 kHz x 32)
DATA_WIDTH, 16, bits per channel sample
FIFO_DEPTH, 4, sample-pair entries buffered (power of 2, >= 2)
MUTE_ON_UNDERRUN, 0, 0 = repeat last pair on underrun; 1 = send zeros

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
en  in  1  run request
smp_valid  in  1  sample pair offered
smp_ready  out  1  FIFO can accept a pair
smp_left  in  DATA_WIDTH  left sample, two's complement
smp_right  in  DATA_WIDTH  right sample, two's complement
aud_bclk  out  1  DAC bit clock
aud_daclrck  out  1  LR clock; 0 = left, 1 = right
aud_dacdat  out  1  serial data, MSB first
underrun  out  1  one-cycle pulse when a frame starts with the FIFO empty
fifo_level  out  $clog2(FIFO_DEPTH)+1  pairs currently buffered
busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset (rst=1 at posedge): state IDLE, FIFO emptied, last-pair register = 0, bclk_cnt = 0, bit_cnt = 0. Outputs aud_bclk, aud_daclrck, aud_dacdat, underrun, busy = 0; fifo_level = 0; smp_ready = 1. Reset mid-frame aborts the frame immediately. No partial-frame completion.
- All outputs are registered. smp_ready = !full, from registered level.
- Push: smp_valid && smp_ready writes {left, right}. A push and a pop in the same cycle are both honoured; level is unchanged. When full, ready = 0 even if a pop occurs that cycle.
- FIFO accepts pushes in every state, including IDLE.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN when en=1 and level != 0. On that edge the head pair is popped into the shift registers, bit_cnt = 0, bclk_cnt = 0, and aud_daclrck = 0. aud_dacdat = left[MSB] is visible the cycle after the transition (1-cycle latency).
  - RUN -> DRAIN when en=0. The current frame continues.
  - DRAIN -> IDLE at the end of the frame (bit_cnt 31 -> wrap). On entering IDLE, bclk, lrck and dat are forced to 0.
  - DRAIN -> RUN if en returns to 1 before the frame ends. No gap occurs.
  - If en=0 in IDLE, the block stays in IDLE.
- Bit timing (RUN/DRAIN):
  - bclk_cnt counts 0..BCLK_HALF-1.
  - At the terminal count, aud_bclk toggles and bclk_cnt returns to 0.
  - Each 1->0 transition of aud_bclk increments bit_cnt (5 bits, 0..31) and shifts the next bit onto aud_dacdat in the same edge.
  - The DAC samples on the BCLK rising edge; data is stable for a full half-period around it.
- Frame: bit_cnt 0..15 carries left MSB..LSB with lrck=0; bit_cnt 16..31 carries right MSB..LSB with lrck=1.
  - lrck changes on the same edge as the falling BCLK that starts bit 0 or bit 16.
  - Frame length = 32 x 2 x BCLK_HALF = 384 clk (48 kHz at 18.432 MHz).
- Frame boundary (bit_cnt wraps 31 -> 0, state RUN):
  - FIFO non-empty: pop the head pair into the shift registers and the last-pair register.
  - FIFO empty: load the last-pair register, or zeros if MUTE_ON_UNDERRUN=1, and pulse underrun for exactly 1 cycle.
- If a push and a frame-boundary pop coincide with an empty FIFO, the result is an underrun. The new pair is written and is used at the next frame.
- Arithmetic: counters wrap modulo their width, with no saturation. fifo_level never exceeds FIFO_DEPTH.

Test Plan:
1. Assert rst for 2 cycles mid-operation -> next cycle: bclk/lrck/dat/underrun/busy = 0, fifo_level = 0, smp_ready = 1; the in-flight frame is abandoned.
2. Push L=16'h8001, R=16'h7FFE, set en=1 -> aud_bclk period 12 clk and aud_daclrck period 384 clk. Bits captured on BCLK rise read 1000_0000_0000_0001 with lrck=0, then 0111_1111_1111_1110 with lrck=1. busy=1.
3. Push one pair, run 3 frames, MUTE_ON_UNDERRUN=0 -> frames 2 and 3 repeat the pair, with one underrun pulse at each boundary. Repeat with MUTE_ON_UNDERRUN=1 -> frames 2 and 3 serialize all zeros.
4. With en=0, hold smp_valid for 5 pairs (DEPTH=4) -> smp_ready drops after the 4th push and fifo_level = 4. After en=1 and the first pop, the 5th pair is accepted, and all pairs are serialized in push order.
5. Drop en at bit_cnt=5 of the left channel -> the frame completes all 32 bits, then the block enters IDLE with outputs 0 and busy=0. Re-raise en before bit 31 in a second run -> the next frame follows with no gap.
6. Push exactly at the frame boundary with the FIFO empty -> underrun pulse fires and the hold pair is sent; the pushed pair appears in the following frame and fifo_level returns to 0.

Source files
------------

// File: rtl/audio_i2s_ctrl.sv
// rtl/audio_i2s_ctrl.sv - I2S DAC sequencer: sample-pair FIFO, BCLK/LRCK generation, frame-aligned start/stop
module audio_i2s_ctrl #(
    parameter int BCLK_HALF        = 6,
    parameter int DATA_WIDTH       = 16,
    parameter int FIFO_DEPTH       = 4,
    parameter int MUTE_ON_UNDERRUN = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        smp_valid,
    output logic                        smp_ready,
    input  logic [DATA_WIDTH-1:0]       smp_left,
    input  logic [DATA_WIDTH-1:0]       smp_right,
    output logic                        aud_bclk,
    output logic                        aud_daclrck,
    output logic                        aud_dacdat,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int BW = $clog2(PW);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t        state, state_next;
    logic [PW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] last_pair, frame_sr, head, load_pair;
    logic [CW-1:0] bclk_cnt;
    logic [BW-1:0] bit_cnt, bit_cnt_inc;
    logic [LW-1:0] level_next;
    logic          fifo_empty, push, pop;
    logic          bclk_tc, bclk_fall, frame_end;
    logic          start, reload, stop, shift;

    assign fifo_empty  = (fifo_level == '0);
    assign push        = smp_valid && smp_ready;
    assign head        = mem[rd_ptr];
    assign bclk_tc     = (bclk_cnt == CW'(BCLK_HALF - 1));
    assign bclk_fall   = (state != IDLE) && bclk_tc && aud_bclk;
    assign frame_end   = bclk_fall && (bit_cnt == BW'(PW - 1));
    assign bit_cnt_inc = bit_cnt + BW'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Stopping is only allowed on a frame boundary so the DAC never sees a partial frame
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en && !fifo_empty) state_next = RUN;
            RUN:     if (!en) state_next = frame_end ? IDLE : DRAIN;
            DRAIN: begin
                if (en)             state_next = RUN;
                else if (frame_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start  = 1'b0;
        reload = 1'b0;
        stop   = 1'b0;
        shift  = 1'b0;
        case (state)
            IDLE: start = (state_next == RUN);
            RUN, DRAIN: begin
                reload = frame_end && (state_next == RUN);
                stop   = (state_next == IDLE);
                shift  = bclk_fall && !frame_end;
            end
            default: ;
        endcase
    end

    assign pop        = start || (reload && !fifo_empty);
    assign load_pair  = !fifo_empty ? head :
                        ((MUTE_ON_UNDERRUN != 0) ? '0 : last_pair);
    assign level_next = fifo_level + LW'(push) - LW'(pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {smp_left, smp_right};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            smp_ready  <= 1'b1;
            last_pair  <= '0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                last_pair <= head;
            end
            fifo_level <= level_next;
            smp_ready  <= (level_next != LW'(FIFO_DEPTH));
            busy       <= (state_next != IDLE);
            underrun   <= reload && fifo_empty;
        end
    end

    // Serializer: the MSB of frame_sr is always the bit currently on aud_dacdat
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_sr    <= '0;
            bclk_cnt    <= '0;
            bit_cnt     <= '0;
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
        end else if (start || reload) begin
            frame_sr    <= load_pair;
            aud_dacdat  <= load_pair[PW-1];
            aud_daclrck <= 1'b0;
            bit_cnt     <= '0;
            bclk_cnt    <= '0;
            aud_bclk    <= 1'b0;
        end else if (stop) begin
            bit_cnt     <= '0;
            bclk_cnt    <= '0;
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
        end else if (state != IDLE) begin
            if (bclk_tc) begin
                bclk_cnt <= '0;
                aud_bclk <= ~aud_bclk;
            end else begin
                bclk_cnt <= bclk_cnt + CW'(1);
            end
            if (shift) begin
                bit_cnt     <= bit_cnt_inc;
                frame_sr    <= frame_sr << 1;
                aud_dacdat  <= frame_sr[PW-2];
                aud_daclrck <= (bit_cnt_inc >= BW'(DATA_WIDTH));
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_ctrl.sv
// tb/tb_audio_i2s_ctrl.sv - self-checking bench for audio_i2s_ctrl against a frame-level model
`timescale 1ns/1ps
module tb_audio_i2s_ctrl;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int HALF  = 6;

    logic          clk = 1'b0, rst = 1'b1, en = 1'b0, smp_valid = 1'b0;
    logic [DW-1:0] smp_left = '0, smp_right = '0;
    logic          smp_ready, aud_bclk, aud_daclrck, aud_dacdat, underrun, busy;
    logic [2:0]    fifo_level;
    logic          m_smp_ready, m_bclk, m_lrck, m_dat, m_underrun, m_busy;
    logic [2:0]    m_fifo_level;

    int checks = 0, errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    audio_i2s_ctrl #(.BCLK_HALF(HALF), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MUTE_ON_UNDERRUN(0)) dut (
        .clk(clk), .rst(rst), .en(en), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_left(smp_left), .smp_right(smp_right), .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck),
        .aud_dacdat(aud_dacdat), .underrun(underrun), .fifo_level(fifo_level), .busy(busy));

    audio_i2s_ctrl #(.BCLK_HALF(HALF), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MUTE_ON_UNDERRUN(1)) dut_mute (
        .clk(clk), .rst(rst), .en(en), .smp_valid(smp_valid), .smp_ready(m_smp_ready),
        .smp_left(smp_left), .smp_right(smp_right), .aud_bclk(m_bclk), .aud_daclrck(m_lrck),
        .aud_dacdat(m_dat), .underrun(m_underrun), .fifo_level(m_fifo_level), .busy(m_busy));

    // Monitor: DAC view of the link, bits captured on each BCLK rise
    logic [1:0] cap0[$], cap1[$];
    int         rise_t[$], lr_t[$];
    int         und_hi0 = 0, und_rise0 = 0, und_hi1 = 0;
    logic       pb0 = 1'b0, pb1 = 1'b0, plr = 1'b0, pu0 = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (aud_bclk && !pb0) begin
            cap0.push_back({aud_daclrck, aud_dacdat});
            rise_t.push_back(cyc);
        end
        if (m_bclk && !pb1) cap1.push_back({m_lrck, m_dat});
        if (aud_daclrck && !plr) lr_t.push_back(cyc);
        if (underrun) und_hi0++;
        if (underrun && !pu0) und_rise0++;
        if (m_underrun) und_hi1++;
        pb0 = aud_bclk;
        pb1 = m_bclk;
        plr = aud_daclrck;
        pu0 = underrun;
    end

    // Frame-level model: each frame takes the oldest queued pair, else holds (or mutes)
    logic [31:0] mq[$];
    logic [31:0] mlast = '0;

    task automatic model_frame(output logic [31:0] e_hold, output logic [31:0] e_mute);
        if (mq.size() > 0) begin
            mlast  = mq.pop_front();
            e_hold = mlast;
            e_mute = mlast;
        end else begin
            e_hold = mlast;
            e_mute = 32'h0;
        end
    endtask

    function automatic logic [31:0] frame_bits(input int inst, input int k, input bit want_lr);
        logic [31:0] w;
        logic [1:0]  e;
        w = '0;
        for (int j = 0; j < 32; j++) begin
            e = (inst == 0) ? cap0[k*32+j] : cap1[k*32+j];
            w[31-j] = want_lr ? e[1] : e[0];
        end
        return w;
    endfunction

    function automatic logic [8:0] outs();
        return {aud_bclk, aud_daclrck, aud_dacdat, underrun, busy, smp_ready, fifo_level};
    endfunction

    task automatic clear_caps();
        cap0.delete(); cap1.delete(); rise_t.delete(); lr_t.delete();
        und_hi0 = 0; und_rise0 = 0; und_hi1 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; smp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        mlast = '0;
        clear_caps();
    endtask

    task automatic push_pair(input logic [31:0] p, output bit ok);
        bit r;
        ok = 1'b0;
        smp_valid = 1'b1;
        {smp_left, smp_right} = p;
        for (int i = 0; i < 2000; i++) begin
            r = smp_ready;
            @(negedge clk);
            if (r) begin ok = 1'b1; break; end
        end
        smp_valid = 1'b0;
        if (ok) mq.push_back(p);
    endtask

    task automatic wait_bits(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < n * 2 * HALF + 2000; i++) begin
            if (cap0.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit ok;
        int n;
        do_reset();
        checks++;
        if (outs() !== 9'b00000_1_000) begin errors++; $display("FAIL reset_outputs: got %b expected %b", outs(), 9'b000001000); end
        push_pair($urandom, ok);
        en = 1'b1;
        wait_bits(10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reset_prerun_timeout: got %0d bits expected 10", cap0.size()); end
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (outs() !== 9'b00000_1_000) begin errors++; $display("FAIL reset_midframe: got %b expected %b", outs(), 9'b000001000); end
        checks++;
        if ({m_bclk, m_lrck, m_dat, m_underrun, m_busy, m_smp_ready, m_fifo_level} !== 9'b00000_1_000) begin
            errors++; $display("FAIL reset_midframe_mute: got %b expected %b",
                {m_bclk, m_lrck, m_dat, m_underrun, m_busy, m_smp_ready, m_fifo_level}, 9'b000001000);
        end
        n = cap0.size();
        repeat (100) @(negedge clk);
        checks++;
        if (cap0.size() != n || busy !== 1'b0) begin
            errors++; $display("FAIL reset_abandon: got %0d bits busy=%b expected %0d bits busy=0", cap0.size(), busy, n);
        end
    endtask

    task automatic test_bit_timing();
        bit ok;
        int bad;
        logic [31:0] e0, e1, f0, f1;
        do_reset();
        push_pair(32'h8001_7FFE, ok);
        en = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, aud_dacdat, aud_daclrck, aud_bclk} !== 4'b1100) begin
            errors++; $display("FAIL first_bit: got %b expected 1100", {busy, aud_dacdat, aud_daclrck, aud_bclk});
        end
        model_frame(e0, f0);
        model_frame(e1, f1);
        wait_bits(66, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timing_timeout: got %0d bits expected 66", cap0.size()); end
        checks++;
        if (frame_bits(0, 0, 0) !== e0) begin errors++; $display("FAIL frame0_data: got %h expected %h", frame_bits(0, 0, 0), e0); end
        checks++;
        if (frame_bits(0, 0, 1) !== 32'h0000FFFF) begin errors++; $display("FAIL frame0_lrck: got %h expected 0000ffff", frame_bits(0, 0, 1)); end
        checks++;
        if (frame_bits(0, 1, 0) !== e1) begin errors++; $display("FAIL frame1_hold: got %h expected %h", frame_bits(0, 1, 0), e1); end
        bad = 0;
        for (int i = 1; i < rise_t.size(); i++) if (rise_t[i] - rise_t[i-1] != 2 * HALF) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bclk_period: got %0d bad periods expected 0", bad); end
        checks++;
        if (lr_t.size() < 2 || lr_t[1] - lr_t[0] != 64 * HALF) begin
            errors++; $display("FAIL lrck_period: got %0d edges, delta %0d expected %0d", lr_t.size(),
                (lr_t.size() >= 2) ? lr_t[1] - lr_t[0] : -1, 64 * HALF);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_run: got %b expected 1", busy); end
        en = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timing_idle_timeout: got busy=%b expected 0", busy); end
    endtask

    task automatic test_underrun();
        bit ok;
        logic [31:0] eh[3], em[3];
        do_reset();
        push_pair($urandom, ok);
        en = 1'b1;
        for (int k = 0; k < 3; k++) model_frame(eh[k], em[k]);
        wait_bits(96, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL underrun_timeout: got %0d bits expected 96", cap0.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (frame_bits(0, k, 0) !== eh[k]) begin errors++; $display("FAIL hold_frame%0d: got %h expected %h", k, frame_bits(0, k, 0), eh[k]); end
            checks++;
            if (frame_bits(1, k, 0) !== em[k]) begin errors++; $display("FAIL mute_frame%0d: got %h expected %h", k, frame_bits(1, k, 0), em[k]); end
        end
        checks++;
        if (und_hi0 != 2 || und_rise0 != 2 || und_hi1 != 2) begin
            errors++; $display("FAIL underrun_pulses: got hi=%0d rise=%0d mute_hi=%0d expected 2 2 2", und_hi0, und_rise0, und_hi1);
        end
        checks++;
        if ({m_busy, m_fifo_level, m_smp_ready} !== {busy, fifo_level, smp_ready}) begin
            errors++; $display("FAIL mute_ctrl_match: got %b expected %b", {m_busy, m_fifo_level, m_smp_ready}, {busy, fifo_level, smp_ready});
        end
        en = 1'b0;
        wait_idle(ok);
    endtask

    task automatic test_fifo_full();
        bit ok;
        logic [31:0] p[5];
        logic [31:0] eh, em;
        do_reset();
        for (int i = 0; i < 5; i++) p[i] = $urandom;
        for (int i = 0; i < 4; i++) push_pair(p[i], ok);
        checks++;
        if (smp_ready !== 1'b0 || fifo_level !== 3'd4) begin errors++; $display("FAIL fifo_full: got ready=%b level=%0d expected 0 4", smp_ready, fifo_level); end
        smp_valid = 1'b1;
        {smp_left, smp_right} = p[4];
        repeat (3) @(negedge clk);
        checks++;
        if (smp_ready !== 1'b0 || fifo_level !== 3'd4) begin errors++; $display("FAIL fifo_hold: got ready=%b level=%0d expected 0 4", smp_ready, fifo_level); end
        en = 1'b1;
        push_pair(p[4], ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fifo_fifth_push: got no accept expected accept"); end
        wait_bits(160, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fifo_timeout: got %0d bits expected 160", cap0.size()); end
        for (int k = 0; k < 5; k++) begin
            model_frame(eh, em);
            checks++;
            if (frame_bits(0, k, 0) !== eh) begin errors++; $display("FAIL fifo_order%0d: got %h expected %h", k, frame_bits(0, k, 0), eh); end
        end
        checks++;
        if (und_rise0 != 0) begin errors++; $display("FAIL fifo_no_underrun: got %0d expected 0", und_rise0); end
        en = 1'b0;
        wait_idle(ok);
    endtask

    task automatic test_drain();
        bit ok;
        logic [31:0] eh, em;
        do_reset();
        push_pair($urandom, ok);
        push_pair($urandom, ok);
        en = 1'b1;
        wait_bits(6, ok);
        en = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || cap0.size() != 32) begin errors++; $display("FAIL drain_bits: got %0d bits expected 32", cap0.size()); end
        model_frame(eh, em);
        checks++;
        if (frame_bits(0, 0, 0) !== eh) begin errors++; $display("FAIL drain_frame: got %h expected %h", frame_bits(0, 0, 0), eh); end
        checks++;
        if ({aud_bclk, aud_daclrck, aud_dacdat, busy, fifo_level} !== 7'b0000_001) begin
            errors++; $display("FAIL drain_idle_outs: got %b expected 0000001", {aud_bclk, aud_daclrck, aud_dacdat, busy, fifo_level});
        end
        clear_caps();
        en = 1'b1;
        push_pair($urandom, ok);
        wait_bits(20, ok);
        en = 1'b0;
        wait_bits(28, ok);
        en = 1'b1;
        wait_bits(64, ok);
        en = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL rerun_timeout: got %0d bits expected 64", cap0.size()); end
        for (int k = 0; k < 2; k++) begin
            model_frame(eh, em);
            checks++;
            if (frame_bits(0, k, 0) !== eh) begin errors++; $display("FAIL rerun_frame%0d: got %h expected %h", k, frame_bits(0, k, 0), eh); end
        end
        checks++;
        if (rise_t.size() < 33 || rise_t[32] - rise_t[31] != 2 * HALF) begin
            errors++; $display("FAIL rerun_gap: got %0d expected %0d", (rise_t.size() >= 33) ? rise_t[32] - rise_t[31] : -1, 2 * HALF);
        end
        wait_idle(ok);
        checks++;
        if (!ok || und_rise0 != 0) begin errors++; $display("FAIL rerun_end: got idle=%b underruns=%0d expected 1 0", ok, und_rise0); end
    endtask

    task automatic test_boundary_push();
        bit ok;
        logic [31:0] eh[3], em[3];
        logic [31:0] p2;
        do_reset();
        p2 = $urandom;
        push_pair($urandom, ok);
        en = 1'b1;
        model_frame(eh[0], em[0]);
        model_frame(eh[1], em[1]);
        wait_bits(32, ok);
        repeat (HALF - 1) @(negedge clk);
        smp_valid = 1'b1;
        {smp_left, smp_right} = p2;
        @(negedge clk);
        smp_valid = 1'b0;
        mq.push_back(p2);
        model_frame(eh[2], em[2]);
        checks++;
        if ({underrun, m_underrun, fifo_level} !== 5'b11_001) begin
            errors++; $display("FAIL boundary_push: got und=%b mute_und=%b level=%0d expected 1 1 1", underrun, m_underrun, fifo_level);
        end
        wait_bits(96, ok);
        en = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL boundary_timeout: got %0d bits expected 96", cap0.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (frame_bits(0, k, 0) !== eh[k] || frame_bits(1, k, 0) !== em[k]) begin
                errors++; $display("FAIL boundary_frame%0d: got %h/%h expected %h/%h", k, frame_bits(0, k, 0), frame_bits(1, k, 0), eh[k], em[k]);
            end
        end
        checks++;
        if (und_hi0 != 1 || fifo_level !== 3'd0) begin errors++; $display("FAIL boundary_after: got und=%0d level=%0d expected 1 0", und_hi0, fifo_level); end
        wait_idle(ok);
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] eh, em;
        do_reset();
        push_pair($urandom, ok);
        en = 1'b1;
        for (int i = 1; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_pair($urandom, ok);
        end
        wait_bits(256, ok);
        en = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL stream_timeout: got %0d bits expected 256", cap0.size()); end
        for (int k = 0; k < 8; k++) begin
            model_frame(eh, em);
            checks++;
            if (frame_bits(0, k, 0) !== eh) begin errors++; $display("FAIL stream_frame%0d: got %h expected %h", k, frame_bits(0, k, 0), eh); end
        end
        checks++;
        if (und_rise0 != 0) begin errors++; $display("FAIL stream_underrun: got %0d expected 0", und_rise0); end
        wait_idle(ok);
    endtask

    initial begin
        test_reset();
        test_bit_timing();
        test_underrun();
        test_fifo_full();
        test_drain();
        test_boundary_push();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
